// File: rtl/match_pkg.sv
// match_pkg -- shared types for the match controller.
//   state_t   : match FSM states (PLAY, HOLD, RESTART, OVER)
//   WIN_*     : two-bit side codes used for round and match winners
package match_pkg;

    typedef enum logic [1:0] {
        ST_PLAY    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RESTART = 2'd2,
        ST_OVER    = 2'd3
    } state_t;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

endpackage

// File: rtl/score_counter.sv
// score_counter -- one player's score register.
//   clk_game  in  game clock
//   reset     in  synchronous active-high reset
//   clear     in  synchronous clear (new match)
//   inc       in  add one to the score
//   load      in  overwrite the score with load_val (takes priority over inc)
//   load_val  in  value for load
//   count     out current score
module score_counter #(
    parameter int SCORE_W = 4
) (
    input  logic               clk_game,
    input  logic               reset,
    input  logic               clear,
    input  logic               inc,
    input  logic               load,
    input  logic [SCORE_W-1:0] load_val,
    output logic [SCORE_W-1:0] count
);

    always_ff @(posedge clk_game) begin
        if (reset || clear)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (inc)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/match_ctrl.sv
// match_ctrl -- match-level controller wrapped around a game core.
// Counts round wins per side, shows each round result for HOLDOFF cycles,
// restarts the core with a one-cycle soft_reset, and declares the match.
//
// Ports:
//   clk_game     in  game clock, all logic on posedge
//   reset        in  synchronous active-high reset
//   done         in  round finished (level from core; rising edge counts)
//   winner       in  round winner: 01 left, 10 right, 00/11 no score
//   in_pulse     in  raw player pulses {left, right}
//   new_match    in  start a new match (honoured only once the match is over)
//   in_gated     out player pulses forwarded to the core (only while playing)
//   soft_reset   out one-cycle core restart pulse
//   score_left   out left score
//   score_right  out right score
//   match_over   out match decided
//   match_winner out 01 left, 10 right, 00 undecided
//
// Build option: define MATCH_CTRL_WIN_BY_TWO_EN to require a two-point lead
// with deuce normalisation; otherwise first to WIN_SCORE wins.
module match_ctrl
    import match_pkg::*;
#(
    parameter int SCORE_W   = 4,
    parameter int WIN_SCORE = 7,
    parameter int HOLDOFF   = 1000,
    parameter int HOLD_W    = 16
) (
    input  logic               clk_game,
    input  logic               reset,
    input  logic               done,
    input  logic [1:0]         winner,
    input  logic [1:0]         in_pulse,
    input  logic               new_match,
    output logic [1:0]         in_gated,
    output logic               soft_reset,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               match_over,
    output logic [1:0]         match_winner
);

    localparam logic [SCORE_W-1:0] WIN_V     = SCORE_W'(WIN_SCORE);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLDOFF - 1);

    state_t state, state_nxt;

    logic               done_q;
    logic               round_end;
    logic               inc_left, inc_right;
    logic [SCORE_W-1:0] nxt_left, nxt_right;
    logic               left_met, right_met, match_met;
    logic               norm_load;
    logic [SCORE_W-1:0] norm_val;
    logic               match_clear;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               hold_done;

    // done_q follows done in every state, so a done level held across
    // RESTART stays masked until it falls.
    always_ff @(posedge clk_game) begin
        if (reset)
            done_q <= 1'b0;
        else
            done_q <= done;
    end

    assign round_end = done & ~done_q & (state == ST_PLAY);
    assign inc_left  = round_end & (winner == WIN_LEFT);
    assign inc_right = round_end & (winner == WIN_RIGHT);

    // Scores as they will be after this edge; the match rule looks ahead so
    // the FSM can go straight to OVER on the deciding round.
    assign nxt_left  = score_left  + {{(SCORE_W-1){1'b0}}, inc_left};
    assign nxt_right = score_right + {{(SCORE_W-1){1'b0}}, inc_right};

`ifdef MATCH_CTRL_WIN_BY_TWO_EN
    // Difference only taken when the leader is strictly ahead, so no wrap.
    assign left_met  = (nxt_left  >= WIN_V) && (nxt_left  > nxt_right) &&
                       ((nxt_left  - nxt_right) >= SCORE_W'(2));
    assign right_met = (nxt_right >= WIN_V) && (nxt_right > nxt_left) &&
                       ((nxt_right - nxt_left)  >= SCORE_W'(2));
    // Tied at or past WIN_SCORE: fold back to WIN_SCORE-1 each, which keeps
    // both scores within WIN_SCORE+1.
    assign norm_load = round_end && (nxt_left == nxt_right) && (nxt_left >= WIN_V);
    assign norm_val  = WIN_V - 1'b1;
`else
    assign left_met  = (nxt_left  == WIN_V);
    assign right_met = (nxt_right == WIN_V);
    assign norm_load = 1'b0;
    assign norm_val  = '0;
`endif

    assign match_met   = round_end & (left_met | right_met);
    assign match_clear = (state == ST_OVER) & new_match;

    score_counter #(.SCORE_W(SCORE_W)) u_score_left (
        .clk_game (clk_game),
        .reset    (reset),
        .clear    (match_clear),
        .inc      (inc_left),
        .load     (norm_load),
        .load_val (norm_val),
        .count    (score_left)
    );

    score_counter #(.SCORE_W(SCORE_W)) u_score_right (
        .clk_game (clk_game),
        .reset    (reset),
        .clear    (match_clear),
        .inc      (inc_right),
        .load     (norm_load),
        .load_val (norm_val),
        .count    (score_right)
    );

    // Holdoff counter: zeroed on the round-end edge, counts while in HOLD.
    always_ff @(posedge clk_game) begin
        if (reset || round_end)
            hold_cnt <= '0;
        else if (state == ST_HOLD)
            hold_cnt <= hold_cnt + 1'b1;
    end

    assign hold_done = (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk_game) begin
        if (reset || match_clear)
            match_winner <= WIN_NONE;
        else if (match_met)
            match_winner <= left_met ? WIN_LEFT : WIN_RIGHT;
    end

    // FSM: state register
    always_ff @(posedge clk_game) begin
        if (reset)
            state <= ST_PLAY;
        else
            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_PLAY:    if (round_end) state_nxt = match_met ? ST_OVER : ST_HOLD;
            ST_HOLD:    if (hold_done) state_nxt = ST_RESTART;
            ST_RESTART: state_nxt = ST_PLAY;
            ST_OVER:    if (new_match) state_nxt = ST_RESTART;
            default:    state_nxt = ST_PLAY;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_gated   = 2'b00;
        soft_reset = 1'b0;
        match_over = 1'b0;
        case (state)
            ST_PLAY:    in_gated   = in_pulse;
            ST_RESTART: soft_reset = 1'b1;
            ST_OVER:    match_over = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: tb/tb_match_ctrl.sv
// tb_match_ctrl -- scoreboard bench for match_ctrl (SCORE_W=4, WIN_SCORE=3,
// HOLDOFF=4). Stimulus pushes the expected output snapshot for the current
// cycle into a queue; a monitor on the falling edge pops and compares.
module tb_match_ctrl;

    logic       clk_game = 1'b0;
    logic       reset;
    logic       done;
    logic [1:0] winner;
    logic [1:0] in_pulse;
    logic       new_match;
    logic [1:0] in_gated;
    logic       soft_reset;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       match_over;
    logic [1:0] match_winner;

    match_ctrl #(
        .SCORE_W   (4),
        .WIN_SCORE (3),
        .HOLDOFF   (4),
        .HOLD_W    (16)
    ) dut (
        .clk_game     (clk_game),
        .reset        (reset),
        .done         (done),
        .winner       (winner),
        .in_pulse     (in_pulse),
        .new_match    (new_match),
        .in_gated     (in_gated),
        .soft_reset   (soft_reset),
        .score_left   (score_left),
        .score_right  (score_right),
        .match_over   (match_over),
        .match_winner (match_winner)
    );

    always #5 clk_game = ~clk_game;

    typedef struct {
        string      nm;
        int         cyc;
        logic [1:0] g;
        logic       sr;
        logic [3:0] sl;
        logic [3:0] srt;
        logic       mo;
        logic [1:0] mw;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [3:0] cur_l = 4'd0;
    logic [3:0] cur_r = 4'd0;

    always @(posedge clk_game) cyc <= cyc + 1;

    // Monitor: compare every expectation queued for the cycle now showing.
    always @(negedge clk_game) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_chk++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d not sampled until cycle %0d",
                         e.nm, e.cyc, cyc);
            end else if ({in_gated, soft_reset, score_left, score_right, match_over, match_winner}
                         !== {e.g, e.sr, e.sl, e.srt, e.mo, e.mw}) begin
                n_fail++;
                $display("FAIL %s: got gated=%b sr=%b L=%0d R=%0d over=%b mw=%b, want gated=%b sr=%b L=%0d R=%0d over=%b mw=%b",
                         e.nm, in_gated, soft_reset, score_left, score_right, match_over, match_winner,
                         e.g, e.sr, e.sl, e.srt, e.mo, e.mw);
            end
        end
    end

    task automatic step();
        @(posedge clk_game);
        #1;
    endtask

    task automatic chk(input string nm, input logic [1:0] g, input logic sr,
                       input logic [3:0] sl, input logic [3:0] srt,
                       input logic mo, input logic [1:0] mw);
        exp_t e;
        e.nm = nm; e.cyc = cyc; e.g = g; e.sr = sr;
        e.sl = sl; e.srt = srt; e.mo = mo; e.mw = mw;
        q.push_back(e);
    endtask

    // One round from PLAY: round end with winner w, then either OVER, or
    // four HOLD cycles, one RESTART cycle and back to PLAY (left unchecked).
    task automatic play_round(input string nm, input logic [1:0] w,
                              input logic [3:0] el, input logic [3:0] er,
                              input logic eo, input logic [1:0] emw);
        done = 1'b1; winner = w;
        chk({nm, "_play"}, in_pulse, 1'b0, cur_l, cur_r, 1'b0, 2'b00);
        step();
        done = 1'b0; winner = 2'b00;
        if (eo) begin
            chk({nm, "_over"}, 2'b00, 1'b0, el, er, 1'b1, emw);
        end else begin
            for (int i = 0; i < 4; i++) begin
                chk({nm, "_hold"}, 2'b00, 1'b0, el, er, 1'b0, 2'b00);
                step();
            end
            chk({nm, "_restart"}, 2'b00, 1'b1, el, er, 1'b0, 2'b00);
            step();
        end
        cur_l = el; cur_r = er;
    endtask

    task automatic start_new(input string nm, input logic [1:0] mw);
        new_match = 1'b1;
        chk({nm, "_req"}, 2'b00, 1'b0, cur_l, cur_r, 1'b1, mw);
        step();
        new_match = 1'b0;
        chk({nm, "_restart"}, 2'b00, 1'b1, 4'd0, 4'd0, 1'b0, 2'b00);
        step();
        chk({nm, "_play"}, in_pulse, 1'b0, 4'd0, 4'd0, 1'b0, 2'b00);
        cur_l = 4'd0; cur_r = 4'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; done = 1'b0; winner = 2'b00; in_pulse = 2'b00; new_match = 1'b0;
        step();
        // Reset wins over a rising done and new_match in the same cycle.
        done = 1'b1; winner = 2'b01; new_match = 1'b1;
        chk("reset_pri", 2'b00, 1'b0, 4'd0, 4'd0, 1'b0, 2'b00);
        step();
        chk("reset_state", 2'b00, 1'b0, 4'd0, 4'd0, 1'b0, 2'b00);
        done = 1'b0; winner = 2'b00; new_match = 1'b0;
        step();
        reset = 1'b0;

        // Gating in PLAY is combinational.
        in_pulse = 2'b10;
        chk("gate_10", 2'b10, 1'b0, 4'd0, 4'd0, 1'b0, 2'b00);
        step();
        in_pulse = 2'b01;
        chk("gate_01", 2'b01, 1'b0, 4'd0, 4'd0, 1'b0, 2'b00);
        step();
        new_match = 1'b1;
        chk("nm_in_play", 2'b01, 1'b0, 4'd0, 4'd0, 1'b0, 2'b00);
        step();
        new_match = 1'b0;
        chk("nm_ignored", 2'b01, 1'b0, 4'd0, 4'd0, 1'b0, 2'b00);
        step();

        // Single left round: HOLD x4, RESTART, PLAY.
        play_round("r1_left", 2'b01, 4'd1, 4'd0, 1'b0, 2'b00);

        // done held high for 10 cycles across RESTART counts once.
        done = 1'b1; winner = 2'b01;
        chk("held_play", 2'b01, 1'b0, 4'd1, 4'd0, 1'b0, 2'b00);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("held_hold", 2'b00, 1'b0, 4'd2, 4'd0, 1'b0, 2'b00);
            step();
        end
        chk("held_restart", 2'b00, 1'b1, 4'd2, 4'd0, 1'b0, 2'b00);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("held_no_recount", 2'b01, 1'b0, 4'd2, 4'd0, 1'b0, 2'b00);
            step();
        end
        done = 1'b0; winner = 2'b00;
        chk("held_release", 2'b01, 1'b0, 4'd2, 4'd0, 1'b0, 2'b00);
        step();

        // Reset in the middle of HOLD at 2-1.
        done = 1'b1; winner = 2'b10;
        chk("mid_hold_play", 2'b01, 1'b0, 4'd2, 4'd0, 1'b0, 2'b00);
        step();
        done = 1'b0; winner = 2'b00;
        chk("mid_hold_1", 2'b00, 1'b0, 4'd2, 4'd1, 1'b0, 2'b00);
        step();
        reset = 1'b1;
        chk("mid_hold_2", 2'b00, 1'b0, 4'd2, 4'd1, 1'b0, 2'b00);
        step();
        reset = 1'b0;
        chk("mid_hold_reset", 2'b01, 1'b0, 4'd0, 4'd0, 1'b0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mid_hold_no_sr", 2'b01, 1'b0, 4'd0, 4'd0, 1'b0, 2'b00);
        end
        cur_l = 4'd0; cur_r = 4'd0;

        // Invalid winner code scores nothing but still restarts the round.
        play_round("r_inv", 2'b11, 4'd0, 4'd0, 1'b0, 2'b00);

        // Right wins three rounds.
        play_round("right1", 2'b10, 4'd0, 4'd1, 1'b0, 2'b00);
        play_round("right2", 2'b10, 4'd0, 4'd2, 1'b0, 2'b00);
        play_round("right3", 2'b10, 4'd0, 4'd3, 1'b1, 2'b10);
        done = 1'b1; winner = 2'b10;
        step();
        chk("over_done_ignored", 2'b00, 1'b0, 4'd0, 4'd3, 1'b1, 2'b10);
        done = 1'b0; winner = 2'b00;
        step();
        chk("over_steady", 2'b00, 1'b0, 4'd0, 4'd3, 1'b1, 2'b10);
        start_new("nm1", 2'b10);
        step();

        // Close game: reach 2-2, then left takes the next round.
        play_round("c_l1", 2'b01, 4'd1, 4'd0, 1'b0, 2'b00);
        play_round("c_r1", 2'b10, 4'd1, 4'd1, 1'b0, 2'b00);
        play_round("c_l2", 2'b01, 4'd2, 4'd1, 1'b0, 2'b00);
        play_round("c_r2", 2'b10, 4'd2, 4'd2, 1'b0, 2'b00);
`ifdef MATCH_CTRL_WIN_BY_TWO_EN
        play_round("c_l3", 2'b01, 4'd3, 4'd2, 1'b0, 2'b00);
        play_round("deuce", 2'b10, 4'd2, 4'd2, 1'b0, 2'b00);
        play_round("adv_l", 2'b01, 4'd3, 4'd2, 1'b0, 2'b00);
        play_round("win_l", 2'b01, 4'd4, 4'd2, 1'b1, 2'b01);
`else
        play_round("c_l3", 2'b01, 4'd3, 4'd2, 1'b1, 2'b01);
`endif
        step();
        start_new("nm2", 2'b01);
        step();
        step();

        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d expectations left, want 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/match_ctrl.md
MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 SHALL have parameter SCORE_W, default 4, score counter width.
REQ-002 SHALL have parameter WIN_SCORE, default 7, rounds needed to win a match; legal range 1 .. 2^SCORE_W-2.
REQ-003 SHALL have parameter HOLDOFF, default 1000, clk_game cycles the round result is displayed before restart; legal range >= 1.
REQ-004 SHALL have parameter HOLD_W, default 16, holdoff counter width; 2^HOLD_W > HOLDOFF.
REQ-005 SHALL have ports, in order:
  clk_game  in  1  game clock, all logic on posedge
  reset  in  1  reset, synchronous, active-high
  done  in  1  round finished, from game core
  winner  in  2  round winner: 01 left, 10 right, 00/11 invalid
  in_pulse  in  2  raw player pulses {left, right}
  new_match  in  1  one-cycle request to start a new match after match over
  in_gated  out  2  player pulses forwarded to the core
  soft_reset  out  1  one-cycle core restart pulse
  score_left  out  SCORE_W  left score
  score_right  out  SCORE_W  right score
  match_over  out  1  match decided
  match_winner  out  2  01 left, 10 right, 00 undecided

Function
REQ-006 SHALL implement FSM states PLAY, HOLD, RESTART, OVER.
REQ-007 PLAY: in_gated = in_pulse, combinationally; all other states: in_gated = 00.
REQ-008 SHALL register done into done_q every cycle; round end = done & ~done_q, acted on only in PLAY.
REQ-009 On round end, winner 01 increments score_left and winner 10 increments score_right, both in the same edge; winner 00/11 scores nothing.
REQ-010 On the round-end edge, if the updated scores satisfy the match rule, next state SHALL be OVER; otherwise it SHALL be HOLD with the holdoff counter cleared.
REQ-011 HOLD: counter increments each cycle; when counter == HOLDOFF-1, next state RESTART (HOLDOFF cycles in HOLD total).
REQ-012 RESTART: soft_reset = 1 for exactly one cycle, then PLAY; soft_reset = 0 in all other states.
REQ-013 OVER: match_over = 1; match_winner = side that met the rule; scores frozen; done edges ignored.
REQ-014 OVER with new_match = 1: scores, match_winner cleared at that edge; next state RESTART.
REQ-015 new_match outside OVER SHALL be ignored.
REQ-016 Base match rule: a score equal to WIN_SCORE ends the match; scores never exceed WIN_SCORE.
REQ-017 A done held high across RESTART SHALL NOT produce a second round end: done_q stays high until done falls.

Reset
REQ-018 reset SHALL force PLAY, scores 0, counter 0, done_q 0, soft_reset 0, match_over 0, match_winner 00, from any state including mid-HOLD and OVER.
REQ-019 reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-020 Macro MATCH_CTRL_WIN_BY_TWO_EN defined: match ends only when a score >= WIN_SCORE and leads the other by >= 2.
REQ-021 With MATCH_CTRL_WIN_BY_TWO_EN defined: if an update leaves both scores equal and >= WIN_SCORE, both SHALL be loaded with WIN_SCORE-1 (deuce normalisation); scores never exceed WIN_SCORE+1.
REQ-022 Macro undefined: REQ-016 rule only; the normalisation logic SHALL be absent.

Structure
REQ-023 Package match_pkg SHALL hold the FSM state enum and the winner codes (WIN_NONE 00, WIN_LEFT 01, WIN_RIGHT 10).
REQ-024 A sub-module score_counter (SCORE_W-bit, sync clear, increment enable, load value) SHALL be instantiated once per side.

Verification (bench: HOLDOFF=4, WIN_SCORE=3, SCORE_W=4)
REQ-025 Reset, then in_pulse=10 in PLAY -> in_gated=10 same cycle; soft_reset 0, scores 0.
REQ-026 done rises with winner=01 -> score_left=1 next edge; in_gated=00 for 4 HOLD cycles; soft_reset one cycle; then PLAY.
REQ-027 done held high 10 cycles across RESTART -> score_left increments once only.
REQ-028 Right wins 3 rounds -> after third round end: match_over=1, match_winner=10, score_right=3, no soft_reset; new_match -> scores 0, one soft_reset pulse, PLAY.
REQ-029 reset asserted mid-HOLD at score 2-1 -> next edge PLAY, scores 0, no soft_reset pulse.
REQ-030 MATCH_CTRL_WIN_BY_TWO_EN: 3-2 then right wins -> 2-2; left, left -> 4-2, match_over=1, match_winner=01; without macro 3-2 ends match at 3.
